// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES control definitions: key-size mode encoding,
//               round counts per key size and the round-controller FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam logic [1:0] MODE_128  = 2'b00;
    localparam logic [1:0] MODE_192  = 2'b01;
    localparam logic [1:0] MODE_256  = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } ctrl_state_e;

    // The reserved encoding falls back to the AES-128 round count.
    function automatic logic [3:0] mode_to_nr(input logic [1:0] mode);
        logic [3:0] nr;
        case (mode)
            MODE_192: nr = NR_192;
            MODE_256: nr = NR_256;
            default:  nr = NR_128;
        endcase
        return nr;
    endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_round_cnt.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_cnt
// Description : Loadable round counter holding the latched round count Nr and
//               flagging the terminal round (rnd == Nr).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_cnt
    import aes_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_nr,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_rnd,
    output logic         o_term
);

    logic [W-1:0] r_rnd_q, w_rnd_d;
    logic [W-1:0] r_nr_q,  w_nr_d;

    // Load starts at round 1: round 0 (the initial AddRoundKey) happens on accept.
    always_comb begin
        w_rnd_d = r_rnd_q;
        w_nr_d  = r_nr_q;
        if (i_load) begin
            w_rnd_d = W'(1);
            w_nr_d  = i_nr;
        end else if (i_inc) begin
            w_rnd_d = r_rnd_q + W'(1);
        end else if (i_clr) begin
            w_rnd_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rnd_q <= '0;
            r_nr_q  <= W'(NR_128);
        end else begin
            r_rnd_q <= w_rnd_d;
            r_nr_q  <= w_nr_d;
        end
    end

    assign o_rnd  = r_rnd_q;
    assign o_term = (r_rnd_q == r_nr_q);

endmodule : aes_round_cnt
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_ctrl
// Description : AES encryption round sequencer. Owns the state register and
//               steps an external round datapath / key store for Nr rounds.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_ctrl #(
    parameter  int MAX_NR = 14,
    localparam int RND_W  = $clog2(MAX_NR + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     din,
    output logic [RND_W-1:0] rk_idx,
    input  logic [127:0]     rk,
    output logic [127:0]     rnd_state,
    output logic             rnd_last,
    input  logic [127:0]     rnd_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     dout,
    output logic             busy
);

    import aes_pkg::*;

    ctrl_state_e      r_state_q, w_state_d;
    logic [127:0]     r_blk_q,   w_blk_d;
    logic             w_accept;
    logic             w_cnt_load, w_cnt_inc, w_cnt_clr;
    logic             w_term;
    logic [RND_W-1:0] w_rnd;
    logic [RND_W-1:0] w_nr_sel;

    assign w_nr_sel = RND_W'(mode_to_nr(mode));
    assign w_accept = (r_state_q == ST_IDLE) && in_valid && !rst;

    aes_round_cnt #(
        .W (RND_W)
    ) u_round_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_cnt_load),
        .i_nr   (w_nr_sel),
        .i_inc  (w_cnt_inc),
        .i_clr  (w_cnt_clr),
        .o_rnd  (w_rnd),
        .o_term (w_term)
    );

    always_comb begin
        w_state_d  = r_state_q;
        w_blk_d    = r_blk_q;
        w_cnt_load = 1'b0;
        w_cnt_inc  = 1'b0;
        w_cnt_clr  = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                // rk_idx is 0 here, so rk is the whitening key.
                if (w_accept) begin
                    w_blk_d    = din ^ rk;
                    w_cnt_load = 1'b1;
                    w_state_d  = ST_ROUND;
                end
            end
            ST_ROUND: begin
                w_blk_d   = rnd_res;
                w_cnt_inc = 1'b1;
                if (w_term) begin
                    w_state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_cnt_clr = 1'b1;
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_blk_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_blk_q   <= w_blk_d;
        end
    end

    assign in_ready  = (r_state_q == ST_IDLE) && !rst;
    assign busy      = (r_state_q != ST_IDLE);
    assign out_valid = (r_state_q == ST_DONE);
    assign rk_idx    = (r_state_q == ST_ROUND) ? w_rnd : '0;
    assign rnd_last  = (r_state_q == ST_ROUND) && w_term;
    assign rnd_state = r_blk_q;
    assign dout      = r_blk_q;

endmodule : aes_round_ctrl
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_round_ctrl
// Description : Bench for aes_round_ctrl with a behavioural AES round datapath
//               and key store, FIPS-197 known answers and random blocks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_ctrl;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] KAT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KAT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] KAT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk;
    logic         rst;
    logic [1:0]   mode;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] din;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic [127:0] rnd_state;
    logic         rnd_last;
    logic [127:0] rnd_res;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] dout;
    logic         busy;

    int           n_vec;
    int           n_miss;
    logic [127:0] rk_tab [16];

    aes_round_ctrl #(.MAX_NR(14)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .rk_idx    (rk_idx),
        .rk        (rk),
        .rnd_state (rnd_state),
        .rnd_last  (rnd_last),
        .rnd_res   (rnd_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- AES arithmetic (FIPS-197) ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from the field inverse (a^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] x;
        inv = 8'h01;
        x   = a;
        for (int i = 1; i < 8; i++) begin
            x   = gmul(x, x);
            inv = gmul(inv, x);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   b [16];
        logic [7:0]   s [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = sbox(st[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++) s[4*c+j] = b[4*((c+j)%4)+j];
        for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            if (last)
                r[127-32*c -: 32] = {a0, a1, a2, a3};
            else
                r[127-32*c -: 32] = {xt(a0) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                                     a0 ^ xt(a1) ^ gmul(a2, 8'h03) ^ a3,
                                     a0 ^ a1 ^ xt(a2) ^ gmul(a3, 8'h03),
                                     gmul(a0, 8'h03) ^ a1 ^ a2 ^ xt(a3)};
        end
        return r ^ k;
    endfunction

    function automatic logic [127:0] round_key(input logic [255:0] key, input int nk, input int idx);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 60; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
    endfunction

    function automatic int nk_of(input logic [1:0] md);
        return (md == 2'b01) ? 6 : (md == 2'b10) ? 8 : 4;
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] blk, input logic [255:0] key,
                                                 input int nk);
        logic [127:0] s;
        s = blk ^ round_key(key, nk, 0);
        for (int r = 1; r <= nk + 6; r++) s = aes_round(s, round_key(key, nk, r), r == nk + 6);
        return s;
    endfunction

    // External key store and round datapath seen by the DUT.
    assign rk      = rk_tab[rk_idx];
    assign rnd_res = aes_round(rnd_state, rk, rnd_last);

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_key(input logic [255:0] key, input int nk);
        for (int i = 0; i < 15; i++) rk_tab[i] = round_key(key, nk, i);
        rk_tab[15] = '0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at #1 after an edge with the DUT idle; leaves at #1 after the out handshake.
    task automatic run_block(input string tag, input logic [127:0] blk, input logic [255:0] key,
                             input logic [1:0] md, input int stall, input bit toggle,
                             input logic [127:0] exp);
        int nk;
        int nr;
        int lat;
        nk = nk_of(md);
        nr = nk + 6;
        load_key(key, nk);
        in_valid = 1'b1;
        din      = blk;
        mode     = md;
        #1;
        check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        din      = rnd128();
        check({tag, "_busy"}, 128'(busy), 128'(1));
        check({tag, "_in_ready_busy"}, 128'(in_ready), 128'(0));
        lat = 0;
        while (!out_valid && lat < 40) begin
            check({tag, "_rk_idx"}, 128'(rk_idx), 128'(lat + 1));
            check({tag, "_rnd_last"}, 128'(rnd_last), 128'(lat + 1 == nr));
            out_ready = 1'($urandom_range(0, 1));
            if (toggle) mode = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'(nr));
        check({tag, "_dout"}, dout, exp);
        check({tag, "_rnd_last_done"}, 128'(rnd_last), 128'(0));
        out_ready = (stall == 0);
        in_valid  = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({tag, "_stall_valid"}, 128'(out_valid), 128'(1));
            check({tag, "_stall_dout"}, dout, exp);
            check({tag, "_stall_in_ready"}, 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, "_hs_valid"}, 128'(out_valid), 128'(0));
        check({tag, "_hs_busy"}, 128'(busy), 128'(0));
        check({tag, "_hs_in_ready"}, 128'(in_ready), 128'(1));
        check({tag, "_hs_state"}, rnd_state, exp);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [127:0] blk;
        logic [255:0] key;
        logic [1:0]   md;
        bit           seen;
        n_vec     = 0;
        n_miss    = 0;
        rst       = 1'b1;
        mode      = 2'b00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din       = '0;
        for (int i = 0; i < 16; i++) rk_tab[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_rk_idx", 128'(rk_idx), 128'(0));
        check("rst_rnd_last", 128'(rnd_last), 128'(0));
        check("rst_dout", dout, 128'(0));
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 128'(in_ready), 128'(1));

        run_block("kat128", PT, KEY, 2'b00, 0, 1'b0, KAT128);
        run_block("kat192_bp", PT, KEY, 2'b01, 5, 1'b0, KAT192);
        run_block("kat256", PT, KEY, 2'b10, 2, 1'b0, KAT256);
        run_block("mode11_toggle", PT, KEY, 2'b11, 1, 1'b1, KAT128);

        // Reset while an AES-256 block is at round 5.
        load_key(KEY, 8);
        in_valid = 1'b1;
        din      = PT;
        mode     = 2'b10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_rk_idx", 128'(rk_idx), 128'(5));
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_out_valid", 128'(out_valid), 128'(0));
        check("mid_rst_in_ready", 128'(in_ready), 128'(0));
        check("mid_rst_rk_idx", 128'(rk_idx), 128'(0));
        check("mid_rst_dout", dout, 128'(0));
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            din = rnd128();
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("mid_rst_no_out", 128'(seen), 128'(0));
        check("idle_state_hold", rnd_state, 128'(0));
        run_block("rst_recover128", PT, KEY, 2'b00, 0, 1'b0, KAT128);

        for (int b = 0; b < 12; b++) begin
            blk = rnd128();
            key = {rnd128(), rnd128()};
            md  = 2'($urandom_range(0, 3));
            run_block($sformatf("rand%0d", b), blk, key, md, $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), ref_encrypt(blk, key, nk_of(md)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_aes_round_ctrl
`default_nettype wire
